// File: rtl/bk_add_operand_feeder_if.sv
// Handshake bundle for bk_add_operand_feeder: the operand input channel,
// the interleaved adder side bus and the registered sum output channel.
// The feeder connects to the slave modport. The master modport is the view
// from the environment around it: the producer, the adder and the consumer.
interface bk_add_operand_feeder_if #(
    parameter int WIDTH = 12
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [2*WIDTH-1:0] add_in;
    logic [WIDTH:0]     add_out;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     out_sum;

    modport slave (
        input  in_valid, in_a, in_b, add_out, out_ready,
        output in_ready, add_in, out_valid, out_sum
    );

    modport master (
        output in_valid, in_a, in_b, add_out, out_ready,
        input  in_ready, add_in, out_valid, out_sum
    );
endinterface

// File: rtl/bk_add_operand_feeder.sv
// Operand feeder around a combinational Brent-Kung adder.
// Operand pairs are buffered in a small FIFO. The head pair is presented
// to the adder in interleaved form, and the adder's sum is registered
// onto a valid/ready output.
// Optional statistics counters are included when BK_ADD_FEEDER_STATS_EN
// is defined.
module bk_add_operand_feeder #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    bk_add_operand_feeder_if.slave        bus
`ifdef BK_ADD_FEEDER_STATS_EN
    ,
    output logic [15:0]                   result_count,
    output logic [15:0]                   carry_count
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] memA_q [DEPTH];
    logic [WIDTH-1:0] memB_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH:0]   outSum_q, outSum_d;

    logic fifoFull;
    logic fifoEmpty;
    logic pushEn;
    logic popEn;
    logic slotFree;

    // Handshake decode. A full FIFO refuses input even if a pop is due this cycle.
    always_comb begin
        fifoFull  = (count_q == FULL_COUNT);
        fifoEmpty = (count_q == '0);
        bus.in_ready = !fifoFull && !rst;
        pushEn    = bus.in_valid && bus.in_ready;
        slotFree  = !outValid_q || bus.out_ready;
        popEn     = !fifoEmpty && slotFree;
    end

    // Interleave the registered head entry onto the adder bus. The bus reads zero when the FIFO is empty.
    always_comb begin
        bus.add_in = '0;
        if (!fifoEmpty) begin
            for (int i = 0; i < WIDTH; i++) begin
                bus.add_in[2*i]   = memA_q[rdPtr_q][i];
                bus.add_in[2*i+1] = memB_q[rdPtr_q][i];
            end
        end
    end

    // Next-state for pointers, occupancy and the result slot.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        outValid_d = outValid_q;
        outSum_d   = outSum_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushEn && !popEn) begin
            count_d = count_q + CNT_W'(1);
        end else if (!pushEn && popEn) begin
            count_d = count_q - CNT_W'(1);
        end
        if (slotFree) begin
            outValid_d = popEn;
            if (popEn) begin
                outSum_d = bus.add_out;
            end
        end
    end

    // Control state register. Reset discards buffered pairs and any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outSum_q   <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            outSum_q   <= outSum_d;
        end
    end

    // Operand storage. Data needs no reset because occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            memA_q[wrPtr_q] <= bus.in_a;
            memB_q[wrPtr_q] <= bus.in_b;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_sum   = outSum_q;

`ifdef BK_ADD_FEEDER_STATS_EN
    logic [15:0] resultCount_q;
    logic [15:0] carryCount_q;

    // Saturating counters of consumed results and of consumed results that carried out.
    always_ff @(posedge clk) begin
        if (rst) begin
            resultCount_q <= '0;
            carryCount_q  <= '0;
        end else if (outValid_q && bus.out_ready) begin
            if (resultCount_q != 16'hFFFF) begin
                resultCount_q <= resultCount_q + 16'd1;
            end
            if (outSum_q[WIDTH] && (carryCount_q != 16'hFFFF)) begin
                carryCount_q <= carryCount_q + 16'd1;
            end
        end
    end

    assign result_count = resultCount_q;
    assign carry_count  = carryCount_q;
`endif
endmodule

// File: doc/bk_add_operand_feeder.md
Name: bk_add_operand_feeder

Overview:
- Upstream/downstream wrapper stage for the 12-bit combinational Brent-Kung adder.
- Accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO.
- Drives the head pair onto the adder's interleaved 24-bit input bus, then registers the 13-bit sum onto a valid/ready output.
- Turns the purely combinational adder into a pipelined, back-pressurable unit.

Parameters:
- WIDTH, 12, operand width; adder input bus is 2*WIDTH, sum is WIDTH+1.
- DEPTH, 2, operand FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  feeder can accept a pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- add_in  output  2*WIDTH  to adder: add_in[2i]=A[i], add_in[2i+1]=B[i]
- add_out  input  WIDTH+1  adder sum; bit WIDTH is carry-out
- out_valid  output  1  out_sum holds an unconsumed result
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH+1  registered sum

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: FIFO empty, rd/wr pointers 0, out_valid=0, out_sum=0, in_ready=0 while rst high, add_in=0.
- Push: on in_valid & in_ready, the {in_a,in_b} pair is written at wr_ptr and wr_ptr increments mod DEPTH.
- in_ready = !full & !rst. Registered count or pointer-plus-wrap-bit distinguishes full from empty.
- No bypass: a full FIFO deasserts in_ready even if a pop happens in the same cycle.
- add_in: interleaved head entry, driven from registered storage, so the adder sees a glitch-free, cycle-stable value. When the FIFO is empty, add_in = 0.
- Result slot:
  - free = !out_valid | out_ready.
  - When FIFO non-empty & free: capture add_out into out_sum, set out_valid=1, pop head (rd_ptr increments mod DEPTH).
  - When free & FIFO empty: out_valid clears; out_sum holds its last value.
  - When out_valid & !out_ready: out_sum and out_valid hold, and no pop occurs.
- Latency: pair accepted at edge N appears on add_in after N and is captured at edge N+1. out_valid is high in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: 1 result/cycle with out_ready held high.
- Simultaneous push and pop (not full): both occur and count is unchanged. Push into an empty FIFO with pop-eligible slot: the pair is captured on the following edge, never in the same cycle.
- Pointer wrap: mod DEPTH. Order is strictly FIFO.
- Reset mid-operation: buffered pairs and any held result are discarded. Outputs return to reset values on the next edge.
- Arithmetic: none inside the feeder. out_sum is exactly add_out, with no truncation or sign handling.
- Handshake rule: once out_valid is high, out_sum must not change until out_ready is seen.

Optional Feature:
- Macro: BK_ADD_FEEDER_STATS_EN.
- Defined:
  - Adds output port result_count[15:0]: increments on each out_valid & out_ready, saturates at 16'hFFFF, reset 0.
  - Adds output port carry_count[15:0]: increments on accepted results with out_sum[WIDTH]=1, saturates at 16'hFFFF, reset 0.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Reset: rst high 3 cycles, then low -> in_ready=1, out_valid=0, out_sum=0, add_in=0.
- Single op: A=12'hFFF, B=12'h001, out_ready=1 -> add_in=24'h555557 one cycle after accept; two cycles after accept out_valid=1, out_sum=13'h1000 for one cycle.
- Back-pressure: out_ready=0, push pairs (1,2),(3,4),(5,6) -> first result 13'h003 held; FIFO full, in_ready=0. Release out_ready -> results 3, 7, 11 in order; in_ready rises the cycle after the first pop.
- Streaming: out_ready=1, in_valid=1 for 8 cycles with A=i, B=2*i -> results 0,3,6,…,21 on 8 consecutive cycles, no bubbles.
- Reset mid-flight: two pairs buffered and out_valid=1, assert rst one cycle -> out_valid=0, FIFO empty, no stale result after release.
- Stats (macro defined): 70000 accepted results of 12'h800+12'h800 -> result_count=16'hFFFF and carry_count=16'hFFFF (saturated). Any mix with 0 carries -> carry_count stays 0.
